// File: rtl/axi_fifo_wr.sv
// AXI4 write-channel buffer: independent AW, W and B register FIFOs between a slave and a master port.
// With W_DELAY=1, an AW is held back until its whole W burst is buffered, so the burst is never starved mid-flight.

module axi_fifo_wr_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_empty
);
  localparam int          PW      = $clog2(DEPTH);
  localparam logic [PW:0] PTR_ONE = (PW + 1)'(1);

  logic [PW:0]      r_wr_ptr;
  logic [PW:0]      r_rd_ptr;
  logic [PW:0]      w_wr_next;
  logic [PW:0]      w_rd_next;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic             r_ready;
  logic             w_push;
  logic             w_pop;
  logic             w_full_next;

  assign w_push      = i_valid & r_ready;
  assign w_pop       = i_pop & ~o_empty;
  assign w_wr_next   = w_push ? r_wr_ptr + PTR_ONE : r_wr_ptr;
  assign w_rd_next   = w_pop  ? r_rd_ptr + PTR_ONE : r_rd_ptr;
  assign w_full_next = (w_wr_next[PW] != w_rd_next[PW]) &&
                       (w_wr_next[PW-1:0] == w_rd_next[PW-1:0]);

  // Ready is registered from the post-update pointers, so it is low in the very cycle the FIFO is full.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_ready  <= 1'b0;
    end else begin
      r_wr_ptr <= w_wr_next;
      r_rd_ptr <= w_rd_next;
      r_ready  <= ~w_full_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (w_push) begin
      r_mem[r_wr_ptr[PW-1:0]] <= i_data;
    end
  end

  assign o_ready = r_ready;
  assign o_empty = (r_wr_ptr == r_rd_ptr);
  assign o_data  = r_mem[r_rd_ptr[PW-1:0]];
endmodule

module axi_fifo_wr #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int STRB_WIDTH = DATA_WIDTH / 8,
  parameter int ID_WIDTH   = 8,
  parameter int AW_FIFO    = 2,
  parameter int W_FIFO     = 16,
  parameter int B_FIFO     = 2,
  parameter int W_DELAY    = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ID_WIDTH-1:0]   s_axi_awid,
  input  logic [ADDR_WIDTH-1:0] s_axi_awaddr,
  input  logic [7:0]            s_axi_awlen,
  input  logic [2:0]            s_axi_awsize,
  input  logic [1:0]            s_axi_awburst,
  input  logic                  s_axi_awlock,
  input  logic [3:0]            s_axi_awqos,
  input  logic                  s_axi_awvalid,
  output logic                  s_axi_awready,
  input  logic [DATA_WIDTH-1:0] s_axi_wdata,
  input  logic [STRB_WIDTH-1:0] s_axi_wstrb,
  input  logic                  s_axi_wlast,
  input  logic                  s_axi_wvalid,
  output logic                  s_axi_wready,
  output logic [ID_WIDTH-1:0]   s_axi_bid,
  output logic [1:0]            s_axi_bresp,
  output logic                  s_axi_bvalid,
  input  logic                  s_axi_bready,
  output logic [ID_WIDTH-1:0]   m_axi_awid,
  output logic [ADDR_WIDTH-1:0] m_axi_awaddr,
  output logic [7:0]            m_axi_awlen,
  output logic [2:0]            m_axi_awsize,
  output logic [1:0]            m_axi_awburst,
  output logic                  m_axi_awlock,
  output logic [3:0]            m_axi_awqos,
  output logic                  m_axi_awvalid,
  input  logic                  m_axi_awready,
  output logic [DATA_WIDTH-1:0] m_axi_wdata,
  output logic [STRB_WIDTH-1:0] m_axi_wstrb,
  output logic                  m_axi_wlast,
  output logic                  m_axi_wvalid,
  input  logic                  m_axi_wready,
  input  logic [ID_WIDTH-1:0]   m_axi_bid,
  input  logic [1:0]            m_axi_bresp,
  input  logic                  m_axi_bvalid,
  output logic                  m_axi_bready
);
  localparam int AW_BITS = ID_WIDTH + ADDR_WIDTH + 8 + 3 + 2 + 1 + 4;
  localparam int W_BITS  = DATA_WIDTH + STRB_WIDTH + 1;
  localparam int B_BITS  = ID_WIDTH + 2;

  logic [AW_BITS-1:0] w_aw_in;
  logic [AW_BITS-1:0] w_aw_out;
  logic [W_BITS-1:0]  w_w_in;
  logic [W_BITS-1:0]  w_w_out;
  logic [B_BITS-1:0]  w_b_in;
  logic [B_BITS-1:0]  w_b_out;
  logic               w_aw_empty;
  logic               w_w_empty;
  logic               w_b_empty;
  logic               w_aw_gate;
  logic               w_w_gate;
  logic               w_aw_pop;
  logic               w_w_pop;

  assign w_aw_in = {s_axi_awid, s_axi_awaddr, s_axi_awlen, s_axi_awsize,
                    s_axi_awburst, s_axi_awlock, s_axi_awqos};
  assign {m_axi_awid, m_axi_awaddr, m_axi_awlen, m_axi_awsize,
          m_axi_awburst, m_axi_awlock, m_axi_awqos} = w_aw_out;
  assign w_w_in = {s_axi_wdata, s_axi_wstrb, s_axi_wlast};
  assign {m_axi_wdata, m_axi_wstrb, m_axi_wlast} = w_w_out;
  assign w_b_in = {m_axi_bid, m_axi_bresp};
  assign {s_axi_bid, s_axi_bresp} = w_b_out;

  assign m_axi_awvalid = ~w_aw_empty & w_aw_gate;
  assign m_axi_wvalid  = ~w_w_empty & w_w_gate;
  assign s_axi_bvalid  = ~w_b_empty;
  assign w_aw_pop      = m_axi_awvalid & m_axi_awready;
  assign w_w_pop       = m_axi_wvalid & m_axi_wready;

  axi_fifo_wr_fifo #(.WIDTH(AW_BITS), .DEPTH(AW_FIFO)) u_aw_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_data  (w_aw_in),
    .i_valid (s_axi_awvalid),
    .o_ready (s_axi_awready),
    .i_pop   (w_aw_pop),
    .o_data  (w_aw_out),
    .o_empty (w_aw_empty)
  );

  axi_fifo_wr_fifo #(.WIDTH(W_BITS), .DEPTH(W_FIFO)) u_w_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_data  (w_w_in),
    .i_valid (s_axi_wvalid),
    .o_ready (s_axi_wready),
    .i_pop   (w_w_pop),
    .o_data  (w_w_out),
    .o_empty (w_w_empty)
  );

  axi_fifo_wr_fifo #(.WIDTH(B_BITS), .DEPTH(B_FIFO)) u_b_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_data  (w_b_in),
    .i_valid (m_axi_bvalid),
    .o_ready (m_axi_bready),
    .i_pop   (s_axi_bvalid & s_axi_bready),
    .o_data  (w_b_out),
    .o_empty (w_b_empty)
  );

  // bcnt: complete bursts sitting in W whose AW is not yet issued; icnt: issued AWs whose burst is not fully sent.
  if (W_DELAY != 0) begin : g_delay
    localparam int            CW     = $clog2(W_FIFO) + 1;
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    logic [CW-1:0] r_bcnt;
    logic [CW-1:0] r_icnt;
    logic          w_burst_in;
    logic          w_burst_out;

    assign w_burst_in  = s_axi_wvalid & s_axi_wready & s_axi_wlast;
    assign w_burst_out = w_w_pop & m_axi_wlast;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_bcnt <= '0;
        r_icnt <= '0;
      end else begin
        case ({w_burst_in, w_aw_pop})
          2'b10:   r_bcnt <= r_bcnt + CNT_ONE;
          2'b01:   r_bcnt <= r_bcnt - CNT_ONE;
          default: r_bcnt <= r_bcnt;
        endcase
        case ({w_aw_pop, w_burst_out})
          2'b10:   r_icnt <= r_icnt + CNT_ONE;
          2'b01:   r_icnt <= r_icnt - CNT_ONE;
          default: r_icnt <= r_icnt;
        endcase
      end
    end

    assign w_aw_gate = (r_bcnt != '0);
    assign w_w_gate  = (r_icnt != '0);
  end else begin : g_nodelay
    assign w_aw_gate = 1'b1;
    assign w_w_gate  = 1'b1;
  end
endmodule

// File: tb/tb_axi_fifo_wr.sv
// Directed bench for axi_fifo_wr: a cycle table for the basic AW/W flow plus hand-written
// sequences for backpressure, the B channel, steady push/pop, W_DELAY gating and mid-burst reset.

module tb_axi_fifo_wr;
  logic        clk = 1'b0;
  logic        rst = 1'b0;

  logic [7:0]  s_axi_awid;
  logic [31:0] s_axi_awaddr;
  logic [7:0]  s_axi_awlen;
  logic [2:0]  s_axi_awsize;
  logic [1:0]  s_axi_awburst;
  logic        s_axi_awlock;
  logic [3:0]  s_axi_awqos;
  logic        s_axi_awvalid;
  logic        s_axi_awready;
  logic [31:0] s_axi_wdata;
  logic [3:0]  s_axi_wstrb;
  logic        s_axi_wlast;
  logic        s_axi_wvalid;
  logic        s_axi_wready;
  logic [7:0]  s_axi_bid;
  logic [1:0]  s_axi_bresp;
  logic        s_axi_bvalid;
  logic        s_axi_bready;
  logic [7:0]  m_axi_awid;
  logic [31:0] m_axi_awaddr;
  logic [7:0]  m_axi_awlen;
  logic [2:0]  m_axi_awsize;
  logic [1:0]  m_axi_awburst;
  logic        m_axi_awlock;
  logic [3:0]  m_axi_awqos;
  logic        m_axi_awvalid;
  logic        m_axi_awready;
  logic [31:0] m_axi_wdata;
  logic [3:0]  m_axi_wstrb;
  logic        m_axi_wlast;
  logic        m_axi_wvalid;
  logic        m_axi_wready;
  logic [7:0]  m_axi_bid;
  logic [1:0]  m_axi_bresp;
  logic        m_axi_bvalid;
  logic        m_axi_bready;

  // Outputs of the W_DELAY=1 instance, which shares all inputs with the plain instance.
  logic        d_s_axi_awready;
  logic        d_s_axi_wready;
  logic [7:0]  d_s_axi_bid;
  logic [1:0]  d_s_axi_bresp;
  logic        d_s_axi_bvalid;
  logic [7:0]  d_m_axi_awid;
  logic [31:0] d_m_axi_awaddr;
  logic [7:0]  d_m_axi_awlen;
  logic [2:0]  d_m_axi_awsize;
  logic [1:0]  d_m_axi_awburst;
  logic        d_m_axi_awlock;
  logic [3:0]  d_m_axi_awqos;
  logic        d_m_axi_awvalid;
  logic [31:0] d_m_axi_wdata;
  logic [3:0]  d_m_axi_wstrb;
  logic        d_m_axi_wlast;
  logic        d_m_axi_wvalid;
  logic        d_m_axi_bready;

  int compareCount = 0;
  int missCount    = 0;

  always #5 clk = ~clk;

  axi_fifo_wr #(.W_DELAY(0)) dut (
    .clk(clk), .rst(rst),
    .s_axi_awid(s_axi_awid), .s_axi_awaddr(s_axi_awaddr), .s_axi_awlen(s_axi_awlen),
    .s_axi_awsize(s_axi_awsize), .s_axi_awburst(s_axi_awburst), .s_axi_awlock(s_axi_awlock),
    .s_axi_awqos(s_axi_awqos), .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
    .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wlast(s_axi_wlast),
    .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
    .s_axi_bid(s_axi_bid), .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid),
    .s_axi_bready(s_axi_bready),
    .m_axi_awid(m_axi_awid), .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen),
    .m_axi_awsize(m_axi_awsize), .m_axi_awburst(m_axi_awburst), .m_axi_awlock(m_axi_awlock),
    .m_axi_awqos(m_axi_awqos), .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
    .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
    .m_axi_bid(m_axi_bid), .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid),
    .m_axi_bready(m_axi_bready)
  );

  axi_fifo_wr #(.W_DELAY(1)) dutDelay (
    .clk(clk), .rst(rst),
    .s_axi_awid(s_axi_awid), .s_axi_awaddr(s_axi_awaddr), .s_axi_awlen(s_axi_awlen),
    .s_axi_awsize(s_axi_awsize), .s_axi_awburst(s_axi_awburst), .s_axi_awlock(s_axi_awlock),
    .s_axi_awqos(s_axi_awqos), .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(d_s_axi_awready),
    .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wlast(s_axi_wlast),
    .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(d_s_axi_wready),
    .s_axi_bid(d_s_axi_bid), .s_axi_bresp(d_s_axi_bresp), .s_axi_bvalid(d_s_axi_bvalid),
    .s_axi_bready(s_axi_bready),
    .m_axi_awid(d_m_axi_awid), .m_axi_awaddr(d_m_axi_awaddr), .m_axi_awlen(d_m_axi_awlen),
    .m_axi_awsize(d_m_axi_awsize), .m_axi_awburst(d_m_axi_awburst), .m_axi_awlock(d_m_axi_awlock),
    .m_axi_awqos(d_m_axi_awqos), .m_axi_awvalid(d_m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_wdata(d_m_axi_wdata), .m_axi_wstrb(d_m_axi_wstrb), .m_axi_wlast(d_m_axi_wlast),
    .m_axi_wvalid(d_m_axi_wvalid), .m_axi_wready(m_axi_wready),
    .m_axi_bid(m_axi_bid), .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid),
    .m_axi_bready(d_m_axi_bready)
  );

  // One table row: inputs for a cycle, then the outputs expected just after that cycle's edge.
  typedef struct {
    logic        awValid;
    logic [31:0] awAddr;
    logic [7:0]  awLen;
    logic        mAwReady;
    logic        wValid;
    logic [31:0] wData;
    logic        wLast;
    logic        mWReady;
    logic        expAwValid;
    logic [31:0] expAwAddr;
    logic        expAwReady;
    logic        expWValid;
    logic [31:0] expWData;
    logic        expWLast;
    logic        expWReady;
  } vec_t;

  vec_t vecs [10];

  // Compares one observed value against the bench's own expectation.
  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    compareCount++;
    if (actual !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Drives every input to its idle value.
  task automatic clearInputs();
    s_axi_awid = '0; s_axi_awaddr = '0; s_axi_awlen = '0; s_axi_awsize = 3'd2;
    s_axi_awburst = 2'd1; s_axi_awlock = 1'b0; s_axi_awqos = '0; s_axi_awvalid = 1'b0;
    s_axi_wdata = '0; s_axi_wstrb = 4'hF; s_axi_wlast = 1'b0; s_axi_wvalid = 1'b0;
    s_axi_bready = 1'b0; m_axi_awready = 1'b0; m_axi_wready = 1'b0;
    m_axi_bid = '0; m_axi_bresp = '0; m_axi_bvalid = 1'b0;
  endtask

  // Full reset; returns one edge after release, when the readies are already up.
  task automatic doReset();
    clearInputs();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // Drives one table row onto the inputs.
  task automatic applyStimulus(input vec_t v);
    s_axi_awvalid = v.awValid;
    s_axi_awaddr  = v.awAddr;
    s_axi_awlen   = v.awLen;
    m_axi_awready = v.mAwReady;
    s_axi_wvalid  = v.wValid;
    s_axi_wdata   = v.wData;
    s_axi_wlast   = v.wLast;
    m_axi_wready  = v.mWReady;
  endtask

  // Advances one clock and samples 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int  sent;
  int  rcv;
  int  cycles;
  logic pushHs;
  logic popHs;

  initial begin
    // Fields: awV, awAddr, awLen, mAwRdy, wV, wData, wLast, mWRdy | expAwV, expAwAddr, expAwRdy, expWV, expWData, expWLast, expWRdy
    vecs[0] = '{1'b1, 32'h100, 8'd3, 1'b1, 1'b0, 32'h0,        1'b0, 1'b1, 1'b1, 32'h100, 1'b1, 1'b0, 32'h0,        1'b0, 1'b1};
    vecs[1] = '{1'b0, 32'h0,   8'd0, 1'b1, 1'b1, 32'hCAFE0000, 1'b0, 1'b1, 1'b0, 32'h0,   1'b1, 1'b1, 32'hCAFE0000, 1'b0, 1'b1};
    vecs[2] = '{1'b0, 32'h0,   8'd0, 1'b1, 1'b1, 32'hCAFE0001, 1'b0, 1'b1, 1'b0, 32'h0,   1'b1, 1'b1, 32'hCAFE0001, 1'b0, 1'b1};
    vecs[3] = '{1'b0, 32'h0,   8'd0, 1'b1, 1'b1, 32'hCAFE0002, 1'b0, 1'b1, 1'b0, 32'h0,   1'b1, 1'b1, 32'hCAFE0002, 1'b0, 1'b1};
    vecs[4] = '{1'b0, 32'h0,   8'd0, 1'b1, 1'b1, 32'hCAFE0003, 1'b1, 1'b1, 1'b0, 32'h0,   1'b1, 1'b1, 32'hCAFE0003, 1'b1, 1'b1};
    vecs[5] = '{1'b0, 32'h0,   8'd0, 1'b1, 1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 32'h0,   1'b1, 1'b0, 32'h0,        1'b0, 1'b1};
    vecs[6] = '{1'b1, 32'h200, 8'd0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 1'b1, 32'h200, 1'b1, 1'b0, 32'h0,        1'b0, 1'b1};
    vecs[7] = '{1'b1, 32'h300, 8'd0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 1'b1, 32'h200, 1'b0, 1'b0, 32'h0,        1'b0, 1'b1};
    vecs[8] = '{1'b0, 32'h0,   8'd0, 1'b1, 1'b0, 32'h0,        1'b0, 1'b1, 1'b1, 32'h300, 1'b1, 1'b0, 32'h0,        1'b0, 1'b1};
    vecs[9] = '{1'b0, 32'h0,   8'd0, 1'b1, 1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 32'h0,   1'b1, 1'b0, 32'h0,        1'b0, 1'b1};

    // Reset state: everything idle and zeroed while rst is held.
    clearInputs();
    #1 rst = 1'b1;
    #1;
    checkOutput("rst_awready", 64'(s_axi_awready), 64'd0);
    checkOutput("rst_wready",  64'(s_axi_wready),  64'd0);
    checkOutput("rst_bready",  64'(m_axi_bready),  64'd0);
    checkOutput("rst_awvalid", 64'(m_axi_awvalid), 64'd0);
    checkOutput("rst_wvalid",  64'(m_axi_wvalid),  64'd0);
    checkOutput("rst_bvalid",  64'(s_axi_bvalid),  64'd0);
    checkOutput("rst_awaddr",  64'(m_axi_awaddr),  64'd0);
    checkOutput("rst_wdata",   64'(m_axi_wdata),   64'd0);
    checkOutput("rst_bid",     64'(s_axi_bid),     64'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    checkOutput("rel_awready_pre", 64'(s_axi_awready), 64'd0);
    tick();
    checkOutput("rel_awready", 64'(s_axi_awready), 64'd1);
    checkOutput("rel_wready",  64'(s_axi_wready),  64'd1);
    checkOutput("rel_bready",  64'(m_axi_bready),  64'd1);
    checkOutput("rel_d_awready", 64'(d_s_axi_awready), 64'd1);

    // Single write plus AW fill/drain, table-driven.
    for (int i = 0; i < 10; i++) begin
      applyStimulus(vecs[i]);
      tick();
      checkOutput($sformatf("vec%0d_awvalid", i), 64'(m_axi_awvalid), 64'(vecs[i].expAwValid));
      checkOutput($sformatf("vec%0d_awready", i), 64'(s_axi_awready), 64'(vecs[i].expAwReady));
      checkOutput($sformatf("vec%0d_wvalid", i),  64'(m_axi_wvalid),  64'(vecs[i].expWValid));
      checkOutput($sformatf("vec%0d_wready", i),  64'(s_axi_wready),  64'(vecs[i].expWReady));
      if (vecs[i].expAwValid)
        checkOutput($sformatf("vec%0d_awaddr", i), 64'(m_axi_awaddr), 64'(vecs[i].expAwAddr));
      if (vecs[i].expWValid) begin
        checkOutput($sformatf("vec%0d_wdata", i), 64'(m_axi_wdata), 64'(vecs[i].expWData));
        checkOutput($sformatf("vec%0d_wlast", i), 64'(m_axi_wlast), 64'(vecs[i].expWLast));
      end
      if (i == 0) checkOutput("vec0_awlen", 64'(m_axi_awlen), 64'd3);
    end

    // W fill to 16 with the master stalled, then drain all 20 beats in order.
    doReset();
    s_axi_wvalid = 1'b1;
    sent = 0;
    cycles = 0;
    while (sent < 16 && cycles < 40) begin
      s_axi_wdata = 32'h1000 + 32'(sent);
      s_axi_wlast = (sent == 19);
      pushHs = s_axi_wready;
      tick();
      cycles++;
      if (pushHs) sent++;
    end
    checkOutput("fill_accepted", 64'(sent), 64'd16);
    checkOutput("fill_cycles", 64'(cycles), 64'd16);
    checkOutput("fill_wready_low", 64'(s_axi_wready), 64'd0);
    s_axi_wdata = 32'h1000 + 32'(sent);
    s_axi_wlast = 1'b0;
    for (int i = 0; i < 5; i++) begin
      checkOutput("stall_wvalid", 64'(m_axi_wvalid), 64'd1);
      checkOutput("stall_wdata",  64'(m_axi_wdata),  64'h1000);
      checkOutput("stall_wready", 64'(s_axi_wready), 64'd0);
      tick();
    end
    m_axi_wready = 1'b1;
    rcv = 0;
    cycles = 0;
    while (rcv < 20 && cycles < 100) begin
      s_axi_wvalid = (sent < 20);
      s_axi_wdata  = 32'h1000 + 32'(sent);
      s_axi_wlast  = (sent == 19);
      pushHs = s_axi_wready & s_axi_wvalid;
      popHs  = m_axi_wvalid;
      if (popHs) begin
        checkOutput($sformatf("drain%0d_wdata", rcv), 64'(m_axi_wdata), 64'(32'h1000 + 32'(rcv)));
        checkOutput($sformatf("drain%0d_wlast", rcv), 64'(m_axi_wlast), 64'(rcv == 19));
      end
      tick();
      cycles++;
      if (pushHs) sent++;
      if (popHs) rcv++;
    end
    checkOutput("drain_count", 64'(rcv), 64'd20);
    s_axi_wvalid = 1'b0;
    checkOutput("drain_empty", 64'(m_axi_wvalid), 64'd0);

    // B response held while the slave stalls.
    doReset();
    checkOutput("b_bready", 64'(m_axi_bready), 64'd1);
    m_axi_bvalid = 1'b1;
    m_axi_bid    = 8'h5A;
    m_axi_bresp  = 2'd2;
    tick();
    m_axi_bvalid = 1'b0;
    m_axi_bid    = 8'h00;
    m_axi_bresp  = 2'd0;
    for (int i = 0; i < 5; i++) begin
      checkOutput("b_hold_valid", 64'(s_axi_bvalid), 64'd1);
      checkOutput("b_hold_id",    64'(s_axi_bid),    64'h5A);
      checkOutput("b_hold_resp",  64'(s_axi_bresp),  64'd2);
      tick();
    end
    s_axi_bready = 1'b1;
    checkOutput("b_final_id", 64'(s_axi_bid), 64'h5A);
    tick();
    checkOutput("b_taken", 64'(s_axi_bvalid), 64'd0);

    // AW half full with continuous push and pop: occupancy and ID order held.
    doReset();
    s_axi_awvalid = 1'b1;
    s_axi_awid    = 8'd0;
    tick();
    m_axi_awready = 1'b1;
    for (int i = 0; i < 50; i++) begin
      s_axi_awid = 8'(i + 1);
      checkOutput($sformatf("pp%0d_id", i), 64'(m_axi_awid), 64'(i));
      checkOutput("pp_valid", 64'(m_axi_awvalid), 64'd1);
      checkOutput("pp_ready", 64'(s_axi_awready), 64'd1);
      tick();
    end
    s_axi_awvalid = 1'b0;
    checkOutput("pp_last_id", 64'(m_axi_awid), 64'd50);
    tick();
    checkOutput("pp_empty", 64'(m_axi_awvalid), 64'd0);

    // W_DELAY=1: AW waits for the full burst, W waits for the AW handshake.
    doReset();
    m_axi_awready = 1'b1;
    m_axi_wready  = 1'b1;
    s_axi_awvalid = 1'b1;
    s_axi_awid    = 8'h33;
    s_axi_awaddr  = 32'h400;
    s_axi_awlen   = 8'd7;
    tick();
    s_axi_awvalid = 1'b0;
    checkOutput("wd_aw_held", 64'(d_m_axi_awvalid), 64'd0);
    checkOutput("wd_w_held",  64'(d_m_axi_wvalid),  64'd0);
    for (int b = 0; b < 8; b++) begin
      s_axi_wvalid = 1'b1;
      s_axi_wdata  = 32'h2000 + 32'(b);
      s_axi_wlast  = (b == 7);
      checkOutput("wd_wready", 64'(d_s_axi_wready), 64'd1);
      tick();
      s_axi_wvalid = 1'b0;
      s_axi_wlast  = 1'b0;
      if (b < 7) begin
        for (int j = 0; j < 3; j++) begin
          checkOutput($sformatf("wd_b%0d_awvalid", b), 64'(d_m_axi_awvalid), 64'd0);
          checkOutput($sformatf("wd_b%0d_wvalid", b),  64'(d_m_axi_wvalid),  64'd0);
          if (j < 2) tick();
        end
      end
    end
    checkOutput("wd_aw_go",    64'(d_m_axi_awvalid), 64'd1);
    checkOutput("wd_aw_addr",  64'(d_m_axi_awaddr),  64'h400);
    checkOutput("wd_aw_len",   64'(d_m_axi_awlen),   64'd7);
    checkOutput("wd_w_wait",   64'(d_m_axi_wvalid),  64'd0);
    tick();
    checkOutput("wd_aw_done",  64'(d_m_axi_awvalid), 64'd0);
    for (int k = 0; k < 8; k++) begin
      checkOutput($sformatf("wd_beat%0d_valid", k), 64'(d_m_axi_wvalid), 64'd1);
      checkOutput($sformatf("wd_beat%0d_data", k),  64'(d_m_axi_wdata),  64'(32'h2000 + 32'(k)));
      checkOutput($sformatf("wd_beat%0d_last", k),  64'(d_m_axi_wlast),  64'(k == 7));
      tick();
    end
    checkOutput("wd_w_done", 64'(d_m_axi_wvalid), 64'd0);

    // Reset in the middle of a burst empties everything at once.
    doReset();
    s_axi_awvalid = 1'b1;
    s_axi_awaddr  = 32'h500;
    s_axi_awlen   = 8'd3;
    s_axi_wvalid  = 1'b1;
    s_axi_wdata   = 32'h3000;
    m_axi_bvalid  = 1'b1;
    m_axi_bid     = 8'h77;
    tick();
    s_axi_awvalid = 1'b0;
    m_axi_bvalid  = 1'b0;
    s_axi_wdata   = 32'h3001;
    tick();
    s_axi_wvalid  = 1'b0;
    checkOutput("mr_pre_wvalid",  64'(m_axi_wvalid),  64'd1);
    checkOutput("mr_pre_awvalid", 64'(m_axi_awvalid), 64'd1);
    checkOutput("mr_pre_bvalid",  64'(s_axi_bvalid),  64'd1);
    rst = 1'b1;
    #1;
    checkOutput("mr_awvalid", 64'(m_axi_awvalid), 64'd0);
    checkOutput("mr_wvalid",  64'(m_axi_wvalid),  64'd0);
    checkOutput("mr_bvalid",  64'(s_axi_bvalid),  64'd0);
    checkOutput("mr_wdata",   64'(m_axi_wdata),   64'd0);
    checkOutput("mr_awready", 64'(s_axi_awready), 64'd0);
    checkOutput("mr_wready",  64'(s_axi_wready),  64'd0);
    checkOutput("mr_bready",  64'(m_axi_bready),  64'd0);
    tick();
    rst = 1'b0;
    #1;
    checkOutput("mr_rel_wvalid",  64'(m_axi_wvalid),  64'd0);
    checkOutput("mr_rel_awready", 64'(s_axi_awready), 64'd0);
    tick();
    checkOutput("mr_post_awready", 64'(s_axi_awready), 64'd1);
    checkOutput("mr_post_wready",  64'(s_axi_wready),  64'd1);
    checkOutput("mr_post_bready",  64'(m_axi_bready),  64'd1);
    checkOutput("mr_post_wvalid",  64'(m_axi_wvalid),  64'd0);
    checkOutput("mr_post_awvalid", 64'(m_axi_awvalid), 64'd0);
    checkOutput("mr_post_bvalid",  64'(s_axi_bvalid),  64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", compareCount, missCount);
    $finish;
  end
endmodule
